// File: rtl/packet_parser_pkg.sv
// Shared command codes, stream control codes and parser state encodings for packet_parser.
package packet_parser_pkg;

    localparam logic [7:0] CMD_PUT     = 8'h01;
    localparam logic [7:0] CMD_FLUSH   = 8'h02;
    localparam logic [7:0] CMD_TCHECK  = 8'h03;
    localparam logic [7:0] CTRL_MODHDR = 8'hFF;
    localparam logic [7:0] CTRL_BODY   = 8'h00;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_PUT_PL  = 3'd2,
        S_CTRL_PL = 3'd3,
        S_DROP    = 3'd4
    } state_t;

    function automatic logic cmd_known(input logic [7:0] cmd);
        return (cmd == CMD_PUT) || (cmd == CMD_FLUSH) || (cmd == CMD_TCHECK);
    endfunction

endpackage

// File: rtl/packet_parser_bswap.sv
// pkt_bswap32: combinational byte reversal of a 32-bit word (little <-> big endian).
module pkt_bswap32 (
    input  logic [31:0] in_word,
    output logic [31:0] out_word
);
    assign out_word = {in_word[7:0], in_word[15:8], in_word[23:16], in_word[31:24]};
endmodule

// File: rtl/packet_parser.sv
// Receive-side stream parser: classifies packets by command byte, writes PUT payload to the RX
// update FIFO, pulses FLUSH/TCHECK events. Optional counters enabled by defining RX_STATS_EN.
module packet_parser
    import packet_parser_pkg::*;
#(
    parameter int DATA_WIDTH           = 64,
    parameter int CTRL_WIDTH           = 8,
    parameter int PUT_HDR_WORDS        = 6,
    parameter int CTRL_HDR_WORDS       = 7,
    parameter int CMD_WORD_IDX         = 5,
    parameter int CMD_LSB              = 0,
    parameter int MAX_WORDS_PER_PACKET = 150
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] rx_update_data,
    output logic                  rx_update_wrreq,
    input  logic                  rx_update_full,
    output logic                  flush_start,
    output logic [31:0]           tcheck_value,
    output logic                  tcheck_valid,
    output logic                  parse_error,
    output logic [31:0]           pkt_count,
    output logic [31:0]           drop_count
);
    localparam int HCW = 4;
    localparam int WCW = $clog2(MAX_WORDS_PER_PACKET + 1);
    localparam logic [HCW-1:0] CMD_IDX_C   = HCW'(CMD_WORD_IDX);
    localparam logic [HCW-1:0] PUT_LAST_C  = HCW'(PUT_HDR_WORDS - 1);
    localparam logic [HCW-1:0] CTRL_LAST_C = HCW'(CTRL_HDR_WORDS - 1);
    localparam logic [WCW-1:0] WR_MAX_C    = WCW'(MAX_WORDS_PER_PACKET);

    state_t                  state_q, state_d;
    logic [HCW-1:0]          hdr_cnt_q, hdr_cnt_d;
    logic [7:0]              cmd_q, cmd_d;
    logic [WCW-1:0]          wr_cnt_q, wr_cnt_d;
    logic                    pkt_err_q, pkt_err_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    wrreq_q, wrreq_d;
    logic                    flush_q, flush_d;
    logic [31:0]             tval_q, tval_d;
    logic                    tvld_q, tvld_d;
    logic                    perr_q, perr_d;

    logic        beat, is_modhdr, is_last;
    logic [7:0]  cmd_in, cmd_eff;
    logic [HCW-1:0] hdr_last_idx;
    logic [31:0] key_be, val_be;

    pkt_bswap32 u_bswap_key (.in_word(in_data[63:32]), .out_word(key_be));
    pkt_bswap32 u_bswap_val (.in_word(in_data[31:0]),  .out_word(val_be));

    assign in_rdy    = ~rx_update_full;
    assign beat      = in_wr & in_rdy;
    assign is_modhdr = (in_ctrl == CTRL_MODHDR);
    assign is_last   = (in_ctrl != CTRL_BODY) && !is_modhdr;
    assign cmd_in    = in_data[CMD_LSB +: 8];
    // Header length depends on the command, which may arrive on this very beat.
    assign cmd_eff      = (hdr_cnt_q == CMD_IDX_C) ? cmd_in : cmd_q;
    assign hdr_last_idx = (cmd_eff == CMD_PUT) ? PUT_LAST_C : CTRL_LAST_C;

    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        cmd_d     = cmd_q;
        wr_cnt_d  = wr_cnt_q;
        pkt_err_d = pkt_err_q;
        rx_data_d = rx_data_q;
        wrreq_d   = 1'b0;
        flush_d   = 1'b0;
        tval_d    = tval_q;
        tvld_d    = 1'b0;
        perr_d    = 1'b0;
        if (beat) begin
            if (is_modhdr) begin
                state_d   = S_HDR;
                hdr_cnt_d = '0;
                wr_cnt_d  = '0;
                pkt_err_d = 1'b0;
                perr_d    = (state_q != S_IDLE);
            end else begin
                case (state_q)
                    S_IDLE: if (!is_last) state_d = S_DROP;
                    S_HDR: begin
                        if (hdr_cnt_q == CMD_IDX_C) cmd_d = cmd_in;
                        if (is_last) begin
                            state_d = S_IDLE;
                            perr_d  = 1'b1;
                        end else if (hdr_cnt_q == CMD_IDX_C && !cmd_known(cmd_in)) begin
                            state_d = S_DROP;
                            perr_d  = 1'b1;
                        end else if (hdr_cnt_q == hdr_last_idx) begin
                            state_d = (cmd_eff == CMD_PUT) ? S_PUT_PL : S_CTRL_PL;
                        end else begin
                            hdr_cnt_d = hdr_cnt_q + 1'b1;
                        end
                    end
                    S_PUT_PL: begin
                        if (wr_cnt_q < WR_MAX_C) begin
                            rx_data_d = {key_be, val_be};
                            wrreq_d   = 1'b1;
                            wr_cnt_d  = wr_cnt_q + 1'b1;
                        end else if (!pkt_err_q) begin
                            perr_d    = 1'b1;
                            pkt_err_d = 1'b1;
                        end
                        if (is_last) state_d = S_IDLE;
                    end
                    S_CTRL_PL: begin
                        if (cmd_q == CMD_FLUSH) begin
                            flush_d = 1'b1;
                        end else begin
                            tval_d = in_data[31:0];
                            tvld_d = 1'b1;
                        end
                        state_d = is_last ? S_IDLE : S_DROP;
                    end
                    S_DROP: if (is_last) state_d = S_IDLE;
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            hdr_cnt_q <= '0;
            cmd_q     <= '0;
            wr_cnt_q  <= '0;
            pkt_err_q <= 1'b0;
            rx_data_q <= '0;
            wrreq_q   <= 1'b0;
            flush_q   <= 1'b0;
            tval_q    <= '0;
            tvld_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            cmd_q     <= cmd_d;
            wr_cnt_q  <= wr_cnt_d;
            pkt_err_q <= pkt_err_d;
            rx_data_q <= rx_data_d;
            wrreq_q   <= wrreq_d;
            flush_q   <= flush_d;
            tval_q    <= tval_d;
            tvld_q    <= tvld_d;
            perr_q    <= perr_d;
        end
    end

    assign rx_update_data  = rx_data_q;
    assign rx_update_wrreq = wrreq_q;
    assign flush_start     = flush_q;
    assign tcheck_value    = tval_q;
    assign tcheck_valid    = tvld_q;
    assign parse_error     = perr_q;

`ifdef RX_STATS_EN
    logic        pkt_good;
    logic [31:0] pkt_count_q, pkt_count_d, drop_count_q, drop_count_d;

    // A good packet is one whose last word lands in a payload state with no error raised.
    assign pkt_good = beat && is_last &&
                      ((state_q == S_PUT_PL && !pkt_err_d) || state_q == S_CTRL_PL);

    always_comb begin
        pkt_count_d  = pkt_count_q + 32'(pkt_good);
        drop_count_d = drop_count_q + 32'(perr_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            pkt_count_q  <= pkt_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign pkt_count  = pkt_count_q;
    assign drop_count = drop_count_q;
`else
    assign pkt_count  = '0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_packet_parser.sv
// Directed self-checking bench for packet_parser: PUT, TCHECK, FLUSH, backpressure, errors, cap, reset.
module tb_packet_parser;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_wr = 1'b0;
    logic        in_rdy;
    logic [63:0] rx_update_data;
    logic        rx_update_wrreq;
    logic        rx_update_full = 1'b0;
    logic        flush_start;
    logic [31:0] tcheck_value;
    logic        tcheck_valid;
    logic        parse_error;
    logic [31:0] pkt_count;
    logic [31:0] drop_count;

    int checks = 0;
    int errors = 0;

    logic [63:0] wq[$];
    int n_fl = 0, n_tv = 0, n_pe = 0;

    packet_parser dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
        .in_rdy(in_rdy), .rx_update_data(rx_update_data), .rx_update_wrreq(rx_update_wrreq),
        .rx_update_full(rx_update_full), .flush_start(flush_start), .tcheck_value(tcheck_value),
        .tcheck_valid(tcheck_valid), .parse_error(parse_error), .pkt_count(pkt_count),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_update_wrreq) wq.push_back(rx_update_data);
        if (flush_start)     n_fl++;
        if (tcheck_valid)    n_tv++;
        if (parse_error)     n_pe++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] stat(input logic [31:0] v);
`ifdef RX_STATS_EN
        return v;
`else
        return (v & 32'h0);
`endif
    endfunction

    function automatic logic [31:0] bs(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Called at a negedge; presents one word for the next posedge.
    task automatic send(input logic [7:0] c, input logic [63:0] d);
        in_ctrl = c; in_data = d; in_wr = 1'b1;
        @(negedge clk);
        in_wr = 1'b0; in_ctrl = '0; in_data = '0;
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input int n);
        send(8'hFF, 64'h0);
        for (int i = 0; i < n; i++)
            send(8'h00, (i == 5) ? {56'h0, cmd} : (64'hCAFE0000_00000000 | 64'(i)));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int b, pe0, fl0, tv0;

    initial begin
        idle(2);
        chk("rst_wrreq", {63'h0, rx_update_wrreq}, 64'h0);
        chk("rst_data", rx_update_data, 64'h0);
        chk("rst_flush", {63'h0, flush_start}, 64'h0);
        chk("rst_tvld", {63'h0, tcheck_valid}, 64'h0);
        chk("rst_tval", {32'h0, tcheck_value}, 64'h0);
        chk("rst_perr", {63'h0, parse_error}, 64'h0);
        chk("rst_pkt", {32'h0, pkt_count}, 64'h0);
        chk("rst_drop", {32'h0, drop_count}, 64'h0);
        chk("rst_rdy", {63'h0, in_rdy}, 64'h1);
        reset = 1'b1;
        idle(2);

        // 1: PUT with three payload words
        b = wq.size(); pe0 = n_pe;
        send_hdr(8'h01, 6);
        send(8'h00, {32'h01000000, 32'h0A000000});
        send(8'h00, 64'h11223344_55667788);
        send(8'h80, 64'hA1B2C3D4_01020304);
        idle(2);
        chk("put_nwr", 64'(wq.size() - b), 64'd3);
        chk("put_w0", wq[b], 64'h00000001_0000000A);
        chk("put_w1", wq[b+1], 64'h44332211_88776655);
        chk("put_w2", wq[b+2], 64'hD4C3B2A1_04030201);
        chk("put_perr", 64'(n_pe - pe0), 64'd0);

        // 2: TCHECK, pulse visible the cycle after the beat
        tv0 = n_tv;
        send_hdr(8'h03, 7);
        send(8'h80, 64'h00000000_DEADBEEF);
        chk("tc_vld_now", {63'h0, tcheck_valid}, 64'h1);
        idle(1);
        chk("tc_vld_drop", {63'h0, tcheck_valid}, 64'h0);
        chk("tc_val", {32'h0, tcheck_value}, 64'hDEADBEEF);
        chk("tc_npulse", 64'(n_tv - tv0), 64'd1);

        // 3: FLUSH
        b = wq.size(); fl0 = n_fl;
        send_hdr(8'h02, 7);
        send(8'h80, 64'h0);
        idle(3);
        chk("fl_npulse", 64'(n_fl - fl0), 64'd1);
        chk("fl_nwr", 64'(wq.size() - b), 64'd0);

        // 4: FIFO full for 10 cycles mid-PUT
        b = wq.size();
        send_hdr(8'h01, 6);
        send(8'h00, 64'h00000010_00000020);
        rx_update_full = 1'b1;
        in_ctrl = 8'h00; in_data = 64'h00000030_00000040; in_wr = 1'b1;
        idle(1);
        chk("full_rdy", {63'h0, in_rdy}, 64'h0);
        idle(9);
        chk("full_nwr", 64'(wq.size() - b), 64'd1);
        rx_update_full = 1'b0;
        idle(1);
        in_wr = 1'b0;
        send(8'h80, 64'h00000050_00000060);
        idle(2);
        chk("full_nwr2", 64'(wq.size() - b), 64'd3);
        chk("full_w0", wq[b], 64'h10000000_20000000);
        chk("full_w1", wq[b+1], 64'h30000000_40000000);
        chk("full_w2", wq[b+2], 64'h50000000_60000000);

        // 5: unknown command, then truncated header, then a good PUT
        b = wq.size(); pe0 = n_pe;
        send_hdr(8'h7E, 6);
        send(8'h00, 64'h1);
        send(8'h80, 64'h2);
        send(8'hFF, 64'h0);
        send(8'h00, 64'h0);
        send(8'h00, 64'h1);
        send(8'h00, 64'h2);
        send(8'h80, 64'h3);
        idle(2);
        chk("err_npulse", 64'(n_pe - pe0), 64'd2);
        chk("err_nwr", 64'(wq.size() - b), 64'd0);
        chk("err_drop", {32'h0, drop_count}, {32'h0, stat(32'd2)});
        send_hdr(8'h01, 6);
        send(8'h00, {32'h02000000, 32'h03000000});
        send(8'h80, {32'h04000000, 32'h05000000});
        idle(2);
        chk("err_resync_nwr", 64'(wq.size() - b), 64'd2);
        chk("err_resync_w0", wq[b], 64'h00000002_00000003);
        chk("err_resync_w1", wq[b+1], 64'h00000004_00000005);
        chk("stat_pkt5", {32'h0, pkt_count}, {32'h0, stat(32'd5)});

        // 6: 152-word PUT is capped at 150 writes with a single error pulse
        b = wq.size(); pe0 = n_pe;
        send_hdr(8'h01, 6);
        for (int i = 0; i < 152; i++)
            send((i == 151) ? 8'h80 : 8'h00, {32'(i), 32'(i) + 32'h100});
        idle(2);
        chk("cap_nwr", 64'(wq.size() - b), 64'd150);
        chk("cap_first", wq[b], {bs(32'd0), bs(32'h100)});
        chk("cap_last", wq[b+149], {bs(32'd149), bs(32'd149 + 32'h100)});
        chk("cap_npulse", 64'(n_pe - pe0), 64'd1);
        chk("cap_drop", {32'h0, drop_count}, {32'h0, stat(32'd3)});
        chk("cap_pkt", {32'h0, pkt_count}, {32'h0, stat(32'd5)});

        // Reset mid-PUT, then resync on the next module header
        send_hdr(8'h01, 6);
        send(8'h00, 64'h0A0B0C0D_01020304);
        send(8'h00, 64'h0A0B0C0D_01020305);
        reset = 1'b0;
        #1;
        chk("mid_rst_wrreq", {63'h0, rx_update_wrreq}, 64'h0);
        chk("mid_rst_data", rx_update_data, 64'h0);
        chk("mid_rst_tval", {32'h0, tcheck_value}, 64'h0);
        chk("mid_rst_drop", {32'h0, drop_count}, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        idle(1);
        b = wq.size();
        send(8'h00, 64'h11111111_11111111);
        send(8'h80, 64'h22222222_22222222);
        send_hdr(8'h01, 6);
        send(8'h80, {32'h78563412, 32'hF0DEBC9A});
        idle(2);
        chk("post_rst_nwr", 64'(wq.size() - b), 64'd1);
        chk("post_rst_w0", wq[b], 64'h12345678_9ABCDEF0);
        chk("post_rst_pkt", {32'h0, pkt_count}, {32'h0, stat(32'd1)});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
